// File: rtl/cic_decim_mc_if.sv
// Sample/strobe/config inputs and serialized result outputs of the multi-channel CIC decimator.
interface cic_decim_mc_if #(
  parameter int CH      = 2,
  parameter int IN_W    = 14,
  parameter int OUT_W   = 32,
  parameter int DECIM_W = 7,
  parameter int CH_W    = 1
);
  logic [DECIM_W-1:0]      decim_i;
  logic [5:0]              shift_i;
  logic [CH*IN_W-1:0]      data_i;
  logic                    data_nd_i;
  logic signed [OUT_W-1:0] data_o;
  logic [CH_W-1:0]         data_ch_o;
  logic                    data_valid_o;
  logic                    overrun_o;

  modport master (
    output decim_i, shift_i, data_i, data_nd_i,
    input  data_o, data_ch_o, data_valid_o, overrun_o
  );

  modport slave (
    input  decim_i, shift_i, data_i, data_nd_i,
    output data_o, data_ch_o, data_valid_o, overrun_o
  );
endinterface

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator: shared strobe and runtime R, per-channel N-stage integrators/combs, serialized output.
// Define CIC_SAT_EN to saturate the scaled output instead of wrapping it to OUT_W bits.
module cic_decim_mc #(
  parameter int CH      = 2,
  parameter int N       = 4,
  parameter int M       = 1,
  parameter int IN_W    = 14,
  parameter int OUT_W   = 32,
  parameter int DECIM_W = 7,
  parameter int ACC_W   = 48,
  parameter int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input logic           clk50,
  input logic           rst,
  cic_decim_mc_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

`ifdef CIC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  function automatic logic signed [OUT_W-1:0] fit_out(input logic signed [ACC_W-1:0] y);
`ifdef CIC_SAT_EN
    if (y > SAT_MAX) return OUT_W'(SAT_MAX);
    if (y < SAT_MIN) return OUT_W'(SAT_MIN);
    return OUT_W'(y);
`else
    return OUT_W'(y);
`endif
  endfunction

  function automatic logic signed [OUT_W-1:0] scale_out(input logic signed [ACC_W-1:0] c,
                                                        input logic [5:0] sh);
    return fit_out(c >>> sh);
  endfunction

  logic [DECIM_W-1:0]      cnt_q, cnt_d, r_act_q, r_act_d;
  logic                    dec;
  logic signed [ACC_W-1:0] integ_q [CH][N];
  logic signed [ACC_W-1:0] integ_d [CH][N];
  logic signed [ACC_W-1:0] stg_q   [CH][N+1];
  logic signed [ACC_W-1:0] dly_q   [CH][N][M];
  logic [N:0]              vld_q;

  always_comb begin
    dec     = bus.data_nd_i && (cnt_q == r_act_q - 1'b1);
    cnt_d   = cnt_q;
    r_act_d = r_act_q;
    if (bus.data_nd_i) begin
      if (dec) begin
        cnt_d   = '0;
        r_act_d = (bus.decim_i == '0) ? DECIM_W'(1) : bus.decim_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Integrator chain uses post-update values of the previous stage within one sample.
  always_comb begin
    logic signed [ACC_W-1:0] acc;
    for (int c = 0; c < CH; c++) begin
      acc = ACC_W'($signed(bus.data_i[c*IN_W +: IN_W]));
      for (int k = 0; k < N; k++) begin
        acc           = integ_q[c][k] + acc;
        integ_d[c][k] = acc;
      end
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      r_act_q <= DECIM_W'(1);
      vld_q   <= '0;
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < N; k++) begin
          integ_q[c][k] <= '0;
          for (int m = 0; m < M; m++) dly_q[c][k][m] <= '0;
        end
        for (int k = 0; k <= N; k++) stg_q[c][k] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      r_act_q <= r_act_d;
      vld_q   <= {vld_q[N-1:0], dec};
      for (int c = 0; c < CH; c++) begin
        // Stage 0: snapshot of the decimating sample's integrator output
        if (bus.data_nd_i) begin
          for (int k = 0; k < N; k++) integ_q[c][k] <= integ_d[c][k];
        end
        if (dec) stg_q[c][0] <= integ_d[c][N-1];
        // Stages 1..N: one comb per cycle, delay lines advance only with a frame
        for (int k = 1; k <= N; k++) begin
          if (vld_q[k-1]) begin
            stg_q[c][k]      <= stg_q[c][k-1] - dly_q[c][k-1][M-1];
            dly_q[c][k-1][0] <= stg_q[c][k-1];
            for (int m = 1; m < M; m++) dly_q[c][k-1][m] <= dly_q[c][k-1][m-1];
          end
        end
      end
    end
  end

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         idx_q, idx_d, ch_q, ch_d;
  logic signed [OUT_W-1:0] res_q [CH];
  logic signed [OUT_W-1:0] data_q, data_d;
  logic                    valid_q, valid_d, ovr_q, ovr_d, load;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    valid_d = 1'b0;
    ovr_d   = 1'b0;
    data_d  = data_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        if (vld_q[N]) begin
          load    = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        valid_d = 1'b1;
        ch_d    = idx_q;
        data_d  = res_q[idx_q];
        if (idx_q == CH_W'(CH-1)) begin
          // Last word frees the latch, so a frame finishing now goes straight out
          if (vld_q[N]) begin
            load  = 1'b1;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + 1'b1;
          ovr_d = vld_q[N];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: latch scaled frame, then emit one channel per cycle
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int c = 0; c < CH; c++) res_q[c] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      if (load) begin
        for (int c = 0; c < CH; c++) res_q[c] <= scale_out(stg_q[c][N], bus.shift_i);
      end
    end
  end

  assign bus.data_o       = data_q;
  assign bus.data_ch_o    = ch_q;
  assign bus.data_valid_o = valid_q;
  assign bus.overrun_o    = ovr_q;

endmodule

// File: tb/tb_cic_decim_mc.sv
// Bench for cic_decim_mc: directed phases plus random stimulus checked against a transfer-function model.
module tb_cic_decim_mc;
  localparam int CH = 4, N = 4, M = 1, IN_W = 14, OUT_W = 20, DECIM_W = 7, ACC_W = 48, CH_W = 2;
  localparam int MAXC = 8192;

  logic clk50 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk50 = ~clk50;

  cic_decim_mc_if #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .DECIM_W(DECIM_W), .CH_W(CH_W)) bus ();

  cic_decim_mc #(.CH(CH), .N(N), .M(M), .IN_W(IN_W), .OUT_W(OUT_W), .DECIM_W(DECIM_W),
                 .ACC_W(ACC_W), .CH_W(CH_W)) dut (
    .clk50 (clk50),
    .rst   (rst),
    .bus   (bus)
  );

  int tests = 0, fails = 0, cyc = 0;

  logic                    exp_v [MAXC];
  logic                    exp_o [MAXC];
  logic signed [OUT_W-1:0] exp_d [MAXC];
  logic [CH_W-1:0]         exp_c [MAXC];

  logic signed [ACC_W-1:0] isum [CH][N];
  logic signed [ACC_W-1:0] hist [CH][N*M+1];
  int cnt, ract, next_free;

  int rec_mode = 0, ovr_cnt = 0, found;
  longint sum0, sum1;
  logic signed [OUT_W-1:0] last_d [CH];
  logic signed [OUT_W-1:0] rec1 [$];
  logic signed [OUT_W-1:0] rec2 [$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
    return r;
  endfunction

  function automatic logic signed [OUT_W-1:0] ref_out(input logic signed [ACC_W-1:0] c, input int sh);
    logic signed [ACC_W-1:0] y;
    longint yl, lim;
    y   = c >>> sh;
    yl  = longint'(y);
    lim = (longint'(1) << (OUT_W - 1)) - 1;
`ifdef CIC_SAT_EN
    if (yl > lim)      return OUT_W'(lim);
    if (yl < -lim - 1) return OUT_W'(-lim - 1);
`endif
    return y[OUT_W-1:0];
  endfunction

  task automatic model_reset();
    cnt = 0; ract = 1; next_free = 0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < N; k++) isum[c][k] = '0;
      for (int j = 0; j <= N*M; j++) hist[c][j] = '0;
    end
    for (int i = cyc + 1; i < MAXC; i++) begin
      exp_v[i] = 1'b0; exp_o[i] = 1'b0; exp_d[i] = '0; exp_c[i] = '0;
    end
  endtask

  // Comb output = N-th lag-M difference of the decimated N-fold running sums.
  task automatic decimate();
    logic signed [ACC_W-1:0] acc, bc;
    int a;
    a = cyc + N + 1;
    for (int c = 0; c < CH; c++) begin
      for (int j = N*M; j > 0; j--) hist[c][j] = hist[c][j-1];
      hist[c][0] = isum[c][N-1];
    end
    if (a >= next_free) begin
      next_free = a + CH;
      for (int c = 0; c < CH; c++) begin
        acc = '0;
        for (int j = 0; j <= N; j++) begin
          bc = ACC_W'(binom(N, j));
          if (j % 2 == 1) acc = acc - bc * hist[c][j*M];
          else            acc = acc + bc * hist[c][j*M];
        end
        exp_v[a+1+c] = 1'b1;
        exp_c[a+1+c] = CH_W'(c);
        exp_d[a+1+c] = ref_out(acc, int'(bus.shift_i));
      end
    end else begin
      exp_o[a] = 1'b1;
    end
  endtask

  task automatic model_edge();
    logic signed [IN_W-1:0] xs;
    if (bus.data_nd_i !== 1'b1) return;
    for (int c = 0; c < CH; c++) begin
      xs = bus.data_i[c*IN_W +: IN_W];
      isum[c][0] = isum[c][0] + ACC_W'(xs);
      for (int k = 1; k < N; k++) isum[c][k] = isum[c][k] + isum[c][k-1];
    end
    if (cnt == ract - 1) begin
      cnt  = 0;
      ract = (bus.decim_i == '0) ? 1 : int'(bus.decim_i);
      decimate();
    end else begin
      cnt++;
    end
  endtask

  task automatic check_cycle();
    chk($sformatf("valid@%0d", cyc), bus.data_valid_o, exp_v[cyc]);
    chk($sformatf("overrun@%0d", cyc), bus.overrun_o, exp_o[cyc]);
    if (exp_v[cyc]) begin
      chk($sformatf("data@%0d", cyc), bus.data_o, exp_d[cyc]);
      chk($sformatf("chan@%0d", cyc), bus.data_ch_o, exp_c[cyc]);
    end
    if (bus.data_valid_o === 1'b1) begin
      last_d[bus.data_ch_o] = bus.data_o;
      if (rec_mode == 1) rec1.push_back(bus.data_o);
      else if (rec_mode == 2) rec2.push_back(bus.data_o);
      if (bus.data_ch_o == 0) sum0 += longint'(bus.data_o);
      else if (bus.data_ch_o == 1) sum1 += longint'(bus.data_o);
    end
    if (bus.overrun_o === 1'b1) ovr_cnt++;
  endtask

  task automatic tick();
    @(posedge clk50);
    cyc++;
    if (!rst) model_edge();
    #1;
    check_cycle();
  endtask

  task automatic set_in(input logic nd, input int v0, input int v1);
    bus.data_nd_i = nd;
    bus.data_i    = '0;
    bus.data_i[0 +: IN_W]    = IN_W'(v0);
    bus.data_i[IN_W +: IN_W] = IN_W'(v1);
  endtask

  task automatic set_rand(input logic nd);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    bus.data_nd_i = nd;
    bus.data_i    = r[CH*IN_W-1:0];
  endtask

  task automatic run_dc(input int n, input int v0, input int v1);
    repeat (n) begin set_in(1'b1, v0, v1); tick(); end
  endtask

  task automatic drain(input int n);
    repeat (n) begin set_in(1'b0, 0, 0); tick(); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      exp_v[i] = 1'b0; exp_o[i] = 1'b0; exp_d[i] = '0; exp_c[i] = '0;
    end
    for (int c = 0; c < CH; c++) last_d[c] = '0;
    bus.decim_i = DECIM_W'(5);
    bus.shift_i = 6'd0;
    set_in(1'b0, 0, 0);
    model_reset();
    repeat (3) tick();
    chk("reset_data", bus.data_o, 0);
    chk("reset_ch", bus.data_ch_o, 0);
    chk("reset_valid", bus.data_valid_o, 0);
    chk("reset_ovr", bus.overrun_o, 0);
    rst = 1'b0;

    // DC, R=5, unscaled then shift 9
    rec_mode = 1;
    run_dc(80, 100, -100);
    rec_mode = 0;
    chk("dc_ch0", last_d[0], 62500);
    chk("dc_ch1", last_d[1], -62500);
    drain(15);
    bus.shift_i = 6'd9;
    run_dc(60, 100, -100);
    chk("dc_sh9_ch0", last_d[0], 122);
    chk("dc_sh9_ch1", last_d[1], -123);
    drain(15);

    // Impulse on ch0
    bus.shift_i = 6'd0;
    do_reset();
    sum0 = 0; sum1 = 0;
    set_in(1'b1, 1, 0); tick();
    run_dc(70, 0, 0);
    drain(15);
    chk("impulse_sum_ch0", sum0, 125);
    chk("impulse_sum_ch1", sum1, 0);

    // R change 5 -> 8 in the middle of a frame
    do_reset();
    run_dc(12, 100, -100);
    bus.decim_i = DECIM_W'(8);
    run_dc(120, 100, -100);
    chk("r8_ch0", last_d[0], 409600);
    chk("r8_ch1", last_d[1], -409600);
    drain(15);

    // R=1 with a strobe every cycle forces dropped frames
    bus.decim_i = DECIM_W'(1);
    ovr_cnt = 0;
    repeat (40) begin set_rand(1'b1); tick(); end
    drain(15);
    chk("overrun_seen", (ovr_cnt > 0), 1);

    // Random phases
    for (int p = 0; p < 3; p++) begin
      bus.shift_i = 6'($urandom_range(0, 8));
      bus.decim_i = DECIM_W'($urandom_range(1, 12));
      for (int t = 0; t < 200; t++) begin
        if (t % 37 == 36) bus.decim_i = DECIM_W'($urandom_range(0, 12));
        set_rand($urandom_range(0, 9) < 7);
        tick();
      end
      drain(20);
    end

    // Full-scale DC: wraps or saturates at OUT_W
    do_reset();
    bus.decim_i = DECIM_W'(5);
    bus.shift_i = 6'd0;
    run_dc(60, 8191, 0);
`ifdef CIC_SAT_EN
    chk("fullscale_ch0", last_d[0], 524287);
`else
    chk("fullscale_ch0", last_d[0], -123505);
`endif
    drain(15);

    // Reset while ch1 word is on the bus, then repeat the first DC run
    do_reset();
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      set_in(1'b1, 100, -100);
      tick();
      if (bus.data_valid_o === 1'b1 && bus.data_ch_o == 1) found = 1;
    end
    chk("ch1_word_seen", found, 1);
    rst = 1'b1;
    #1;
    chk("rst_valid_drop", bus.data_valid_o, 0);
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    rec_mode = 2;
    run_dc(80, 100, -100);
    rec_mode = 0;
    chk("rerun_len", rec2.size(), rec1.size());
    for (int i = 0; i < rec1.size() && i < rec2.size(); i++)
      chk($sformatf("rerun_word%0d", i), rec2[i], rec1[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
